skolem_check_xor4: RTL and testbench

SKOLEM_CHECK_XOR4 -- requirements
Module: skolem_check_xor4

---
 rtl/skolem_check_xor4_if.sv | 37 +++
 rtl/skolem_check_xor4.sv | 141 ++++++++++++++
 tb/tb_skolem_check_xor4.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/skolem_check_xor4_if.sv
// Handshake and candidate-probe signals shared between a sweep controller
// (master) and the skolem_check_xor4 checker (slave).
interface skolem_check_xor4_if;
    logic       start;
    logic [3:0] cand_in;
    logic       cand_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_cnt;
    logic [3:0] cex;
    logic       cex_valid;

    modport master (
        output start,
        output cand_out,
        input  cand_in,
        input  busy,
        input  done,
        input  pass,
        input  fail_cnt,
        input  cex,
        input  cex_valid
    );

    modport slave (
        input  start,
        input  cand_out,
        output cand_in,
        output busy,
        output done,
        output pass,
        output fail_cnt,
        output cex,
        output cex_valid
    );
endinterface

// File: rtl/skolem_check_xor4.sv
// Exhaustive checker for a candidate Skolem function i4 = f(i0..i3) against
// the relation i0^i1^i2^i3^i4 == 1. Each of the 16 assignments gets one
// settle cycle (APPLY) and one compare cycle (CHECK), so a full sweep takes
// 32 cycles plus a one-cycle DONE.
// Optional feature: define SKOLEM_CHECK_STOP_ON_FAIL_EN to end the sweep at
// the first failing assignment.
module skolem_check_xor4 (
    input  logic                    clk,
    input  logic                    rst,
    skolem_check_xor4_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] index;
    logic [4:0] fail_cnt_q;
    logic [3:0] cex_q;
    logic       cex_valid_q;
    logic       pass_q;

    logic       expected;
    logic       mismatch;
    logic       last_index;

    assign expected   = ~(^index);
    assign mismatch   = (state == CHECK) && (bus.cand_out != expected);
    assign last_index = (index == 4'd15);

    // State register; reset returns the sweep to IDLE regardless of progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so any start seen while busy is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                state_next = CHECK;
            end
            CHECK: begin
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
                if (mismatch || last_index) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                end
`else
                if (last_index) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: index stepping, saturating failure count, first counterexample capture and held verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            index       <= 4'd0;
            fail_cnt_q  <= 5'd0;
            cex_q       <= 4'd0;
            cex_valid_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        index       <= 4'd0;
                        fail_cnt_q  <= 5'd0;
                        cex_q       <= 4'd0;
                        cex_valid_q <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (fail_cnt_q != 5'd16) begin
                            fail_cnt_q <= fail_cnt_q + 5'd1;
                        end
                        if (!cex_valid_q) begin
                            cex_q       <= index;
                            cex_valid_q <= 1'b1;
                        end
                    end
                    if (state_next == APPLY) begin
                        index <= index + 4'd1;
                    end
                end
                DONE: begin
                    pass_q <= (fail_cnt_q == 5'd0);
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: the verdict is shown live during DONE and then held from pass_q while idle.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.cand_in   = 4'd0;
        bus.pass      = pass_q;
        bus.fail_cnt  = fail_cnt_q;
        bus.cex       = cex_q;
        bus.cex_valid = cex_valid_q;
        if (state == APPLY || state == CHECK) begin
            bus.cand_in = index;
        end
        if (state == DONE) begin
            bus.pass = (fail_cnt_q == 5'd0);
        end
    end

endmodule

// File: tb/tb_skolem_check_xor4.sv
// Directed bench for skolem_check_xor4: runs sweeps against three candidate
// functions (correct XNOR, constant 1, inverted XOR), an ignored mid-sweep
// start and a mid-sweep reset, with hand-computed expected values.
module tb_skolem_check_xor4;

    logic       clk;
    logic       rst;
    logic [1:0] cand_mode;

    int checks = 0;
    int errors = 0;

    skolem_check_xor4_if bus();

    skolem_check_xor4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Candidate function under test: 0 = correct XNOR, 1 = constant 1, otherwise XOR.
    always_comb begin
        case (cand_mode)
            2'd0:    bus.cand_out = ~(^bus.cand_in);
            2'd1:    bus.cand_out = 1'b1;
            default: bus.cand_out = ^bus.cand_in;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in the current cycle (cycle 0) and watches the sweep for a bounded number of cycles.
    task automatic applyStimulus(input int extra_start_at,
                                 output int done_cycle, output int done_count, output int busy_gaps,
                                 output logic [3:0] cand3, output logic [3:0] cand31,
                                 output logic [4:0] fc, output logic [3:0] cx,
                                 output logic cxv, output logic ps);
        done_cycle = -1;
        done_count = 0;
        busy_gaps  = 0;
        cand3      = 4'd0;
        cand31     = 4'd0;
        fc         = 5'd0;
        cx         = 4'd0;
        cxv        = 1'b0;
        ps         = 1'b0;
        bus.start  = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            nextCycle();
            bus.start = (c == extra_start_at);
            if (c == 3)  cand3  = bus.cand_in;
            if (c == 31) cand31 = bus.cand_in;
            if (bus.done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle = c;
                    fc  = bus.fail_cnt;
                    cx  = bus.cex;
                    cxv = bus.cex_valid;
                    ps  = bus.pass;
                end
            end
            if ((done_cycle < 0 || done_cycle == c) && bus.busy !== 1'b1) busy_gaps++;
            if (done_cycle >= 0 && c >= done_cycle + 3) break;
        end
        bus.start = 1'b0;
    endtask

    int         done_cycle;
    int         done_count;
    int         busy_gaps;
    logic [3:0] cand3;
    logic [3:0] cand31;
    logic [4:0] fc;
    logic [3:0] cx;
    logic       cxv;
    logic       ps;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        cand_mode = 2'd0;
        repeat (3) nextCycle();
        checkOutput("reset_busy",      bus.busy,      0);
        checkOutput("reset_done",      bus.done,      0);
        checkOutput("reset_pass",      bus.pass,      0);
        checkOutput("reset_fail_cnt",  bus.fail_cnt,  0);
        checkOutput("reset_cex_valid", bus.cex_valid, 0);
        checkOutput("reset_cand_in",   bus.cand_in,   0);
        rst = 1'b0;
        nextCycle();

        $display("[TB] sweep with correct XNOR candidate");
        cand_mode = 2'd0;
        applyStimulus(0, done_cycle, done_count, busy_gaps, cand3, cand31, fc, cx, cxv, ps);
        checkOutput("xnor_done_cycle", done_cycle, 33);
        checkOutput("xnor_done_count", done_count, 1);
        checkOutput("xnor_busy_gaps",  busy_gaps,  0);
        checkOutput("xnor_cand3",      cand3,      1);
        checkOutput("xnor_cand31",     cand31,     15);
        checkOutput("xnor_fail_cnt",   fc,         0);
        checkOutput("xnor_cex_valid",  cxv,        0);
        checkOutput("xnor_pass",       ps,         1);
        checkOutput("idle_pass_held",  bus.pass,   1);
        checkOutput("idle_busy",       bus.busy,   0);
        checkOutput("idle_cand_in",    bus.cand_in, 0);

        $display("[TB] sweep with constant-1 candidate");
        cand_mode = 2'd1;
        applyStimulus(0, done_cycle, done_count, busy_gaps, cand3, cand31, fc, cx, cxv, ps);
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
        checkOutput("const1_done_cycle", done_cycle, 5);
        checkOutput("const1_fail_cnt",   fc,         1);
`else
        checkOutput("const1_done_cycle", done_cycle, 33);
        checkOutput("const1_fail_cnt",   fc,         8);
`endif
        checkOutput("const1_cex",        cx,         1);
        checkOutput("const1_cex_valid",  cxv,        1);
        checkOutput("const1_pass",       ps,         0);
        checkOutput("const1_idle_fail",  bus.fail_cnt, fc);
        checkOutput("const1_idle_cex",   bus.cex,    1);

        $display("[TB] sweep with inverted XOR candidate");
        cand_mode = 2'd2;
        applyStimulus(0, done_cycle, done_count, busy_gaps, cand3, cand31, fc, cx, cxv, ps);
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
        checkOutput("xor_done_cycle", done_cycle, 3);
        checkOutput("xor_fail_cnt",   fc,         1);
`else
        checkOutput("xor_done_cycle", done_cycle, 33);
        checkOutput("xor_fail_cnt",   fc,         16);
`endif
        checkOutput("xor_cex",        cx,         0);
        checkOutput("xor_cex_valid",  cxv,        1);
        checkOutput("xor_pass",       ps,         0);

        $display("[TB] start pulse during a running sweep");
        cand_mode = 2'd0;
        applyStimulus(5, done_cycle, done_count, busy_gaps, cand3, cand31, fc, cx, cxv, ps);
        checkOutput("restart_done_cycle", done_cycle, 33);
        checkOutput("restart_done_count", done_count, 1);
        checkOutput("restart_pass",       ps,         1);

        $display("[TB] reset in the middle of a sweep");
        cand_mode = 2'd1;
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            bus.start = 1'b0;
        end
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("midrst_busy",      bus.busy,      0);
        checkOutput("midrst_done",      bus.done,      0);
        checkOutput("midrst_pass",      bus.pass,      0);
        checkOutput("midrst_fail_cnt",  bus.fail_cnt,  0);
        checkOutput("midrst_cex",       bus.cex,       0);
        checkOutput("midrst_cex_valid", bus.cex_valid, 0);
        checkOutput("midrst_cand_in",   bus.cand_in,   0);
        nextCycle();
        applyStimulus(0, done_cycle, done_count, busy_gaps, cand3, cand31, fc, cx, cxv, ps);
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
        checkOutput("midrst_restart_done", done_cycle + 12, 17);
        checkOutput("midrst_restart_fail", fc, 1);
`else
        checkOutput("midrst_restart_done", done_cycle + 12, 45);
        checkOutput("midrst_restart_fail", fc, 8);
`endif
        checkOutput("midrst_restart_cex", cx, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
